// File: rtl/reglk_bank.sv
// reglk_bank: register-lock bank with write-once seals, 1-cycle bus, JTAG unlock.
// Optional macro REGLK_PARITY_EN adds per-word even parity with fail-locked output.
module reglk_bank #(
  parameter int NB_WORDS      = 6,
  parameter int WORD_W        = 32,
  parameter int ADDR_W        = 8,
  parameter int UNLOCK_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       jtag_unlock_i,
  input  logic [7:0]                 reglk_ctrl_i,
  input  logic                       acct_ctrl_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [63:0]                wdata_i,
  output logic                       gnt_o,
  output logic                       rvalid_o,
  output logic [63:0]                rdata_o,
  output logic                       err_o,
  output logic [NB_WORDS*WORD_W-1:0] reglk_ctrl_o,
  output logic                       parity_err_o
);

  localparam int CW = $clog2(UNLOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CLEAR = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NB_WORDS-1:0][WORD_W-1:0] words_q;
  logic [NB_WORDS-1:0] seal_q;
  logic [NB_WORDS-1:0] word_hit;
  logic [NB_WORDS-1:0] wr_word;
  logic [NB_WORDS-1:0] par_bad;

  logic [ADDR_W-4:0] idx;
  logic [31:0] idx32;
  logic is_word, is_seal, is_stat;
  logic sel_seal, wr_ok, seal_set, clr;
  logic [WORD_W-1:0] rd_word;
  logic rsp_err;
  logic [63:0] rsp_data;
  logic unused;

  assign unused  = ^{reglk_ctrl_i, wdata_i, addr_i};
  assign clr     = (state_q == CLEAR);
  assign gnt_o   = req_i & ~clr;
  assign idx     = addr_i[ADDR_W-1:3];
  assign idx32   = 32'(idx);
  assign is_word = idx32 < 32'(NB_WORDS);
  assign is_seal = idx32 == 32'(NB_WORDS);
  assign is_stat = idx32 == 32'(NB_WORDS + 1);

  // Unlock FSM state and debounce counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unlock FSM next state: a full run of high cycles is needed to clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (jtag_unlock_i) begin
          state_d = ARM;
          cnt_d   = CW'(1);
        end
      end
      ARM: begin
        if (!jtag_unlock_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(UNLOCK_CYCLES - 1)) begin
          state_d = CLEAR;
          cnt_d   = CW'(UNLOCK_CYCLES);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CLEAR: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        cnt_d = '0;
        if (!jtag_unlock_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Address decode, write qualification and response data
  always_comb begin
    word_hit = '0;
    rd_word  = '0;
    for (int k = 0; k < NB_WORDS; k++) begin
      word_hit[k] = is_word && (idx32 == 32'(k));
      if (word_hit[k]) rd_word = words_q[k];
    end
    sel_seal = |(word_hit & seal_q);
    wr_ok    = gnt_o && acct_ctrl_i && we_i && is_word &&
               !reglk_ctrl_i[1] && !sel_seal;
    wr_word  = wr_ok ? word_hit : '0;
    seal_set = gnt_o && acct_ctrl_i && we_i && is_seal;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if (!acct_ctrl_i) begin
      rsp_err = 1'b1;
    end else if (is_word) begin
      if (we_i) rsp_err = reglk_ctrl_i[1] | sel_seal;
      else if (!reglk_ctrl_i[0]) rsp_data = 64'(rd_word);
    end else if (is_seal) begin
      if (!we_i) rsp_data = 64'(seal_q);
    end else if (is_stat) begin
      if (we_i) rsp_err = 1'b1;
      else rsp_data = 64'({state_q, parity_err_o, |seal_q});
    end else begin
      rsp_err = 1'b1;
    end
  end

  // Lock words and seals; CLEAR wins over any same-cycle update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
      seal_q  <= '0;
    end else if (clr) begin
      words_q <= '0;
      seal_q  <= '0;
    end else begin
      for (int k = 0; k < NB_WORDS; k++)
        if (wr_word[k]) words_q[k] <= wdata_i[WORD_W-1:0];
      if (seal_set) seal_q <= seal_q | wdata_i[NB_WORDS-1:0];
    end
  end

  // Bus response, one cycle after grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= gnt_o;
      err_o    <= gnt_o & rsp_err;
      rdata_o  <= gnt_o ? rsp_data : '0;
    end
  end

`ifdef REGLK_PARITY_EN
  logic [NB_WORDS-1:0] par_q;
  logic perr_q;

  // Even parity mismatch per stored word
  always_comb begin
    par_bad = '0;
    for (int k = 0; k < NB_WORDS; k++)
      par_bad[k] = (^words_q[k]) ^ par_q[k];
  end

  // Parity bits follow word writes; error flag is sticky until CLEAR
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else if (clr) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      for (int k = 0; k < NB_WORDS; k++)
        if (wr_word[k]) par_q[k] <= ^wdata_i[WORD_W-1:0];
      if (|par_bad) perr_q <= 1'b1;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign par_bad      = '0;
  assign parity_err_o = 1'b0;
`endif

  // Lock vector; a corrupted word fails locked
  always_comb begin
    reglk_ctrl_o = '0;
    for (int k = 0; k < NB_WORDS; k++)
      reglk_ctrl_o[k*WORD_W +: WORD_W] = par_bad[k] ? '1 : words_q[k];
  end

endmodule

// File: tb/tb_reglk_bank.sv
// tb_reglk_bank: directed vector table plus unlock/parity sequences.
// Build with +define+REGLK_PARITY_EN to exercise the parity path.
module tb_reglk_bank;

  localparam int NW = 6;
  localparam int WW = 32;
  localparam int U  = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic jtag_unlock_i = 1'b0;
  logic [7:0] reglk_ctrl_i = '0;
  logic acct_ctrl_i = 1'b1;
  logic req_i = 1'b0;
  logic we_i = 1'b0;
  logic [7:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic gnt_o, rvalid_o, err_o, parity_err_o;
  logic [63:0] rdata_o;
  logic [NW*WW-1:0] reglk_ctrl_o;

  int checks = 0;
  int errors = 0;

  reglk_bank #(
    .NB_WORDS(NW), .WORD_W(WW), .ADDR_W(8), .UNLOCK_CYCLES(U)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .jtag_unlock_i(jtag_unlock_i),
    .reglk_ctrl_i(reglk_ctrl_i), .acct_ctrl_i(acct_ctrl_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .reglk_ctrl_o(reglk_ctrl_o), .parity_err_o(parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    int          idx;
    logic [63:0] wdata;
    logic [7:0]  ctrl;
    logic        acct;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic bus(input logic we, input int idx, input logic [63:0] wd,
                     input logic [7:0] ctrl, input logic acct,
                     output logic g, output logic rv0, output logic rv,
                     output logic [63:0] rd, output logic e);
    @(negedge clk_i);
    req_i = 1'b1;
    we_i = we;
    addr_i = 8'(idx << 3);
    wdata_i = wd;
    reglk_ctrl_i = ctrl;
    acct_ctrl_i = acct;
    #1;
    g = gnt_o;
    rv0 = rvalid_o;
    @(negedge clk_i);
    rv = rvalid_o;
    rd = rdata_o;
    e = err_o;
    req_i = 1'b0;
    we_i = 1'b0;
    reglk_ctrl_i = '0;
    acct_ctrl_i = 1'b1;
  endtask

  task automatic op(input string n, input logic we, input int idx,
                    input logic [63:0] wd, input logic exp_err,
                    input logic [63:0] exp_rd);
    logic g, rv0, rv, e;
    logic [63:0] rd;
    bus(we, idx, wd, 8'h00, 1'b1, g, rv0, rv, rd, e);
    chk({n, " err"}, 64'(e), 64'(exp_err));
    chk({n, " rdata"}, rd, exp_rd);
  endtask

  initial begin
    logic g, rv0, rv, e;
    logic [63:0] rd;

    vecs[0]  = '{1'b0, 0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 5, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 2, 64'hA5A5_0001, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 2, 64'h0, 8'h00, 1'b1, 1'b0, 64'hA5A5_0001};
    vecs[5]  = '{1'b1, 6, 64'h4, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 6, 64'h0, 8'h00, 1'b1, 1'b0, 64'h4};
    vecs[7]  = '{1'b1, 2, 64'h0, 8'h00, 1'b1, 1'b1, 64'h0};
    vecs[8]  = '{1'b0, 2, 64'h0, 8'h00, 1'b1, 1'b0, 64'hA5A5_0001};
    vecs[9]  = '{1'b1, 3, 64'h1234_5678, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 3, 64'h0, 8'h00, 1'b1, 1'b0, 64'h1234_5678};
    vecs[11] = '{1'b1, 0, 64'h1111, 8'h02, 1'b1, 1'b1, 64'h0};
    vecs[12] = '{1'b0, 0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 2, 64'h0, 8'h01, 1'b1, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 2, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0};
    vecs[15] = '{1'b1, 0, 64'hDEAD_BEEF, 8'h00, 1'b0, 1'b1, 64'h0};
    vecs[16] = '{1'b0, 0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[17] = '{1'b0, 7, 64'h0, 8'h00, 1'b1, 1'b0, 64'h1};
    vecs[18] = '{1'b0, 8, 64'h0, 8'h00, 1'b1, 1'b1, 64'h0};
    vecs[19] = '{1'b0, 31, 64'h0, 8'h00, 1'b1, 1'b1, 64'h0};
    vecs[20] = '{1'b1, 4, 64'hFFFF_0000_0000_00C3, 8'h00, 1'b1, 1'b0, 64'h0};
    vecs[21] = '{1'b0, 4, 64'h0, 8'h00, 1'b1, 1'b0, 64'hC3};
    vecs[22] = '{1'b1, 6, 64'hFFFF_FFFF_FFFF_FFC0, 8'h00, 1'b1, 1'b0, 64'h0};

    #12;
    chk("rst gnt", 64'(gnt_o), 64'h0);
    chk("rst rvalid", 64'(rvalid_o), 64'h0);
    chk("rst err", 64'(err_o), 64'h0);
    chk("rst rdata", rdata_o, 64'h0);
    chk("rst lock", 64'(|reglk_ctrl_o), 64'h0);
    chk("rst perr", 64'(parity_err_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      bus(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].ctrl, vecs[i].acct,
          g, rv0, rv, rd, e);
      chk($sformatf("v%0d gnt", i), 64'(g), 64'h1);
      chk($sformatf("v%0d rvalid early", i), 64'(rv0), 64'h0);
      chk($sformatf("v%0d rvalid", i), 64'(rv), 64'h1);
      chk($sformatf("v%0d err", i), 64'(e), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
    end

    op("seal hi bits", 1'b0, 6, 64'h0, 1'b0, 64'h4);
    chk("lock w0", 64'(reglk_ctrl_o[31:0]), 64'h0);
    chk("lock w2", 64'(reglk_ctrl_o[95:64]), 64'hA5A5_0001);
    chk("lock w3", 64'(reglk_ctrl_o[127:96]), 64'h1234_5678);
    chk("lock w4", 64'(reglk_ctrl_o[159:128]), 64'hC3);

`ifdef REGLK_PARITY_EN
    @(negedge clk_i);
    dut.words_q[1][0] = ~dut.words_q[1][0];
    #1;
    chk("par lock w1", 64'(reglk_ctrl_o[63:32]), 64'hFFFF_FFFF);
    @(negedge clk_i);
    chk("par err", 64'(parity_err_o), 64'h1);
    op("par status", 1'b0, 7, 64'h0, 1'b0, 64'h3);
`endif

    @(negedge clk_i);
    jtag_unlock_i = 1'b1;
    repeat (U - 1) @(negedge clk_i);
    jtag_unlock_i = 1'b0;
    repeat (2) @(negedge clk_i);
    op("short jtag w2", 1'b0, 2, 64'h0, 1'b0, 64'hA5A5_0001);
    op("short jtag seal", 1'b0, 6, 64'h0, 1'b0, 64'h4);

    @(negedge clk_i);
    jtag_unlock_i = 1'b1;
    repeat (U - 1) @(negedge clk_i);
    req_i = 1'b1;
    we_i = 1'b0;
    addr_i = 8'd0;
    #1;
    chk("arm gnt", 64'(gnt_o), 64'h1);
    @(negedge clk_i);
    #1;
    chk("clear gnt", 64'(gnt_o), 64'h0);
    chk("clear rvalid", 64'(rvalid_o), 64'h1);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("post clear rvalid", 64'(rvalid_o), 64'h0);
    chk("clear lock", 64'(|reglk_ctrl_o), 64'h0);
    chk("clear perr", 64'(parity_err_o), 64'h0);
    op("hold status", 1'b0, 7, 64'h0, 1'b0, 64'hC);
    op("hold seal", 1'b0, 6, 64'h0, 1'b0, 64'h0);
    repeat (3) @(negedge clk_i);
    op("hold status 2", 1'b0, 7, 64'h0, 1'b0, 64'hC);
    jtag_unlock_i = 1'b0;
    @(negedge clk_i);
    op("idle status", 1'b0, 7, 64'h0, 1'b0, 64'h0);
    op("rewrite w2", 1'b1, 2, 64'h77, 1'b0, 64'h0);
    chk("rewrite lock", 64'(reglk_ctrl_o[95:64]), 64'h77);

    @(negedge clk_i);
    jtag_unlock_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midarm rst lock", 64'(|reglk_ctrl_o), 64'h0);
    jtag_unlock_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    op("midarm status", 1'b0, 7, 64'h0, 1'b0, 64'h0);
    op("midarm w2", 1'b0, 2, 64'h0, 1'b0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
